// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port memory: grant, issue, capture, acknowledge.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module mem_port_arbiter #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Req0,
    input  logic          Req1,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic          RW0,
    input  logic          RW1,
    input  logic [DW-1:0] WData0,
    input  logic [DW-1:0] WData1,
    output logic          Gnt0,
    output logic          Gnt1,
    output logic          Ack0,
    output logic          Ack1,
    output logic [DW-1:0] RData,
    output logic [AW-1:0] MemAddr,
    output logic          MemRW,
    output logic          MemEn,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    output logic          Busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t        state, state_nxt;
    logic          latch;
    logic          pick;
    logic          win_q;
    logic [AW-1:0] addr_q;
    logic          rw_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    // On a tie the requester not served last wins; reset value favours requester 0.
    always_comb pick = (Req0 && Req1) ? ~last_q : ~Req0;

    always_ff @(posedge Clk) begin
        if (Rst)
            last_q <= 1'b1;
        else if (latch)
            last_q <= pick;
    end
`else
    always_comb pick = ~Req0;
`endif

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        Gnt0      = 1'b0;
        Gnt1      = 1'b0;
        Ack0      = 1'b0;
        Ack1      = 1'b0;
        MemEn     = 1'b0;
        MemRW     = 1'b0;
        MemAddr   = '0;
        MemWData  = '0;
        Busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    latch     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = CAPTURE;
                MemEn     = 1'b1;
                MemRW     = rw_q;
                MemAddr   = addr_q;
                MemWData  = wdata_q;
            end
            CAPTURE: state_nxt = DONE;
            DONE: begin
                state_nxt = IDLE;
                Ack0      = ~win_q;
                Ack1      = win_q;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE) begin
            Gnt0 = ~win_q;
            Gnt1 = win_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            win_q   <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                win_q   <= pick;
                addr_q  <= pick ? Addr1 : Addr0;
                rw_q    <= pick ? RW1 : RW0;
                wdata_q <= pick ? WData1 : WData0;
            end
            if (state == CAPTURE && !rw_q)
                rdata_q <= MemRData;
        end
    end

    assign RData = rdata_q;

endmodule
